// File: rtl/mmcm_drp_reconfig.sv
// MMCM pixel-clock retune controller: management writes stage N/M/C0, start runs DRP RMW.
// Optional `MMCM_DRP_TIMEOUT_EN adds a DRDY watchdog that aborts and flags error.
module mmcm_drp_reconfig #(
    parameter int DRP_TIMEOUT = 1023,
    parameter bit LOCK_WAIT   = 1'b1
) (
    input  logic        mgmt_clk,
    input  logic        mgmt_reset_n,
    input  logic [5:0]  mgmt_address,
    input  logic        mgmt_write,
    input  logic [31:0] mgmt_writedata,
    input  logic        mgmt_read,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_waitrequest,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    output logic        drp_den,
    output logic        drp_dwe,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    typedef enum logic [3:0] {
        IDLE, ASRT_RST, RD_REQ, RD_WAIT, WR_REQ,
        WR_WAIT, NEXT, RELEASE, WAIT_LOCK
    } state_t;

    state_t      state, state_n;
    logic [17:0] n_word, m_word, c0_word;
    logic        n_dirty, m_dirty, c0_dirty;
    logic [2:0]  idx, idx_n, first_idx, next_idx;
    logic [4:0]  reg_en;
    logic [15:0] rd_data, merged;
    logic [6:0]  reg_addr;
    logic [1:0]  lock_ff;
    logic        locked_sync, wr_ok, start_wr, clr_dirty;
    logic        waiting, tmo_hit, error, busy;
    logic        unused_wdata;

    function automatic logic [5:0] clamp6(input logic [7:0] v);
        return (v > 8'd63) ? 6'd63 : v[5:0];
    endfunction

    function automatic logic [11:0] hilo(input logic [17:0] w);
        return {clamp6(w[15:8]), clamp6(w[7:0])};
    endfunction

    assign unused_wdata = ^mgmt_writedata[31:23];
    assign locked_sync  = lock_ff[1];
    assign busy         = (state != IDLE);
    assign wr_ok        = mgmt_write && !busy;
    assign start_wr     = wr_ok && (mgmt_address == 6'd2);
    assign waiting      = (state == RD_WAIT) || (state == WR_WAIT);
    assign reg_en       = {n_dirty, m_dirty, m_dirty, c0_dirty, c0_dirty};

    // Register walk order 0x08, 0x09, 0x14, 0x15, 0x16; index 5 means done.
    always_comb begin
        first_idx = 3'd5;
        next_idx  = 3'd5;
        for (int i = 4; i >= 0; i--) begin
            if (reg_en[i]) first_idx = 3'(i);
            if (reg_en[i] && (3'(i) > idx)) next_idx = 3'(i);
        end
    end

    always_comb begin
        reg_addr = 7'h00;
        merged   = 16'h0000;
        case (idx)
            3'd0: begin
                reg_addr = 7'h08;
                merged   = {rd_data[15:12], hilo(c0_word)};
            end
            3'd1: begin
                reg_addr = 7'h09;
                merged   = {rd_data[15:8], c0_word[16], c0_word[17], rd_data[5:0]};
            end
            3'd2: begin
                reg_addr = 7'h14;
                merged   = {rd_data[15:12], hilo(m_word)};
            end
            3'd3: begin
                reg_addr = 7'h15;
                merged   = {rd_data[15], 4'b0000, rd_data[10:8],
                            m_word[16], m_word[17], rd_data[5:0]};
            end
            3'd4: begin
                reg_addr = 7'h16;
                merged   = {rd_data[15:14], n_word[17], n_word[16], hilo(n_word)};
            end
            default: ;
        endcase
    end

    assign drp_den          = (state == RD_REQ) || (state == WR_REQ);
    assign drp_dwe          = (state == WR_REQ);
    assign drp_daddr        = drp_den ? reg_addr : 7'h00;
    assign drp_di           = drp_dwe ? merged : 16'h0000;
    assign mgmt_waitrequest = busy;
    assign mmcm_rst         = busy && (state != RELEASE) && (state != WAIT_LOCK);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        clr_dirty = 1'b0;
        case (state)
            IDLE: if (start_wr && (|reg_en)) begin
                state_n = ASRT_RST;
                idx_n   = first_idx;
            end
            ASRT_RST: state_n = RD_REQ;
            RD_REQ:   state_n = RD_WAIT;
            RD_WAIT: begin
                if (drp_drdy) state_n = WR_REQ;
                else if (tmo_hit) begin
                    state_n   = IDLE;
                    clr_dirty = 1'b1;
                end
            end
            WR_REQ: state_n = WR_WAIT;
            WR_WAIT: begin
                if (drp_drdy) state_n = NEXT;
                else if (tmo_hit) begin
                    state_n   = IDLE;
                    clr_dirty = 1'b1;
                end
            end
            NEXT: begin
                if (next_idx == 3'd5) begin
                    state_n   = RELEASE;
                    clr_dirty = 1'b1;
                end else begin
                    state_n = RD_REQ;
                    idx_n   = next_idx;
                end
            end
            RELEASE:   state_n = LOCK_WAIT ? WAIT_LOCK : IDLE;
            WAIT_LOCK: if (locked_sync) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            state         <= IDLE;
            idx           <= 3'd0;
            rd_data       <= 16'h0000;
            lock_ff       <= 2'b00;
            mgmt_readdata <= 32'h0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            lock_ff <= {lock_ff[0], mmcm_locked};
            if ((state == RD_WAIT) && drp_drdy) rd_data <= drp_do;
            if (mgmt_read && (mgmt_address == 6'd1))
                mgmt_readdata <= {29'b0, error, busy, locked_sync};
            else
                mgmt_readdata <= 32'h0;
        end
    end

    // Staging writes only land while idle; the master is stalled otherwise.
    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            n_word   <= 18'h00101;
            m_word   <= 18'h00101;
            c0_word  <= 18'h00101;
            n_dirty  <= 1'b0;
            m_dirty  <= 1'b0;
            c0_dirty <= 1'b0;
        end else if (clr_dirty) begin
            n_dirty  <= 1'b0;
            m_dirty  <= 1'b0;
            c0_dirty <= 1'b0;
        end else if (wr_ok) begin
            unique case (1'b1)
                (mgmt_address == 6'd3): begin
                    n_word  <= mgmt_writedata[17:0];
                    n_dirty <= 1'b1;
                end
                (mgmt_address == 6'd4): begin
                    m_word  <= mgmt_writedata[17:0];
                    m_dirty <= 1'b1;
                end
                (mgmt_address == 6'd5) && (mgmt_writedata[22:18] == 5'd0): begin
                    c0_word  <= mgmt_writedata[17:0];
                    c0_dirty <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MMCM_DRP_TIMEOUT_EN
    localparam int TW = $clog2(DRP_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit = waiting && !drp_drdy && (tmo_cnt == TW'(DRP_TIMEOUT - 1));

    always_ff @(posedge mgmt_clk or negedge mgmt_reset_n) begin
        if (!mgmt_reset_n) begin
            tmo_cnt <= '0;
            error   <= 1'b0;
        end else begin
            if (drp_den) tmo_cnt <= '0;
            else if (waiting) tmo_cnt <= tmo_cnt + 1'b1;
            if (start_wr) error <= 1'b0;
            else if (tmo_hit) error <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = DRP_TIMEOUT;
    logic unused_wait;
    assign unused_wait = waiting;
    assign tmo_hit     = 1'b0;
    assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a behavioural DRP/MMCM model.
// Timeout scenario runs only when MMCM_DRP_TIMEOUT_EN is defined.
module tb_mmcm_drp_reconfig;

    localparam int TMO = 16;

    logic        mgmt_clk = 1'b0;
    logic        mgmt_reset_n;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_read;
    logic [31:0] mgmt_readdata;
    logic        mgmt_waitrequest;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_do;
    logic        drp_drdy;
    logic        mmcm_rst;
    logic        mmcm_locked;

    always #5 mgmt_clk = ~mgmt_clk;

    mmcm_drp_reconfig #(.DRP_TIMEOUT(TMO), .LOCK_WAIT(1'b1)) dut (
        .mgmt_clk(mgmt_clk), .mgmt_reset_n(mgmt_reset_n),
        .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_read(mgmt_read),
        .mgmt_readdata(mgmt_readdata), .mgmt_waitrequest(mgmt_waitrequest),
        .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den),
        .drp_dwe(drp_dwe), .drp_do(drp_do), .drp_drdy(drp_drdy),
        .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] mem [0:127];
    logic [6:0]  log_a [0:63];
    logic        log_w [0:63];
    logic [15:0] log_d [0:63];
    int          log_n;
    int          pend;
    logic [15:0] rd_val;
    bit          hold_rd = 1'b0;
    bit          hold_wr = 1'b0;
    bit          lock_auto = 1'b0;
    bit          lock_force = 1'b0;
    int          lock_cnt;
    int          wreq_cnt = 0;
    int          rst_cnt = 0;
    int          den_norst = 0;
    bit          t4_wr_done = 1'b0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] word;
        int          nreg;
        logic [6:0]  ra;
        logic [15:0] ia;
        logic [15:0] ea;
        logic [6:0]  rb;
        logic [15:0] ib;
        logic [15:0] eb;
    } vec_t;

    vec_t        vecs [6];
    logic [6:0]  t4_addr [5];
    logic [15:0] t4_data [5];
    logic [31:0] rdata;
    int          base, n, w0, r0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic mm_write(input logic [5:0] a, input logic [31:0] d);
        int k = 0;
        @(negedge mgmt_clk);
        mgmt_address   = a;
        mgmt_writedata = d;
        mgmt_write     = 1'b1;
        while (mgmt_waitrequest && k < 500) begin
            @(negedge mgmt_clk);
            k++;
        end
        @(posedge mgmt_clk);
        #1 mgmt_write = 1'b0;
    endtask

    task automatic mm_read(input logic [5:0] a, output logic [31:0] d);
        @(negedge mgmt_clk);
        mgmt_address = a;
        mgmt_read    = 1'b1;
        @(posedge mgmt_clk);
        #1 mgmt_read = 1'b0;
        d = mgmt_readdata;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        @(negedge mgmt_clk);
        while (mgmt_waitrequest && k < budget) begin
            @(negedge mgmt_clk);
            k++;
        end
        check(name, mgmt_waitrequest, 1'b0);
    endtask

    // DRP slave: DRDY two cycles after DEN unless held.
    initial begin
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        pend     = 0;
        log_n    = 0;
        forever begin
            @(posedge mgmt_clk);
            #1;
            drp_drdy = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    drp_drdy = 1'b1;
                    drp_do   = rd_val;
                end
            end
            if (drp_den) begin
                if (log_n < 64) begin
                    log_a[log_n] = drp_daddr;
                    log_w[log_n] = drp_dwe;
                    log_d[log_n] = drp_di;
                end
                log_n++;
                if (drp_dwe) begin
                    mem[drp_daddr] = drp_di;
                    if (!hold_wr) pend = 2;
                end else begin
                    rd_val = mem[drp_daddr];
                    if (!hold_rd) pend = 2;
                end
            end
        end
    end

    // MMCM lock: drops under reset, relocks a few cycles after release.
    initial begin
        mmcm_locked = 1'b0;
        lock_cnt    = 0;
        forever begin
            @(posedge mgmt_clk);
            #1;
            if (mmcm_rst) begin
                mmcm_locked = 1'b0;
                lock_cnt    = 0;
            end else if (lock_force) begin
                mmcm_locked = 1'b1;
            end else if (lock_auto && !mmcm_locked) begin
                lock_cnt++;
                if (lock_cnt >= 4) mmcm_locked = 1'b1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge mgmt_clk);
            if (mgmt_waitrequest) wreq_cnt++;
            if (mmcm_rst) rst_cnt++;
            if (drp_den && !mmcm_rst) den_norst++;
        end
    end

    initial begin
        vecs[0] = '{6'd5, 32'h0000_0908, 2, 7'h08, 16'hF000, 16'hF248, 7'h09, 16'h12F4, 16'h1234};
        // Only [14:11] is cleared on 0x15, so bit 10 of 0x7C00 survives.
        vecs[1] = '{6'd4, 32'h0002_1919, 2, 7'h14, 16'hA000, 16'hA659, 7'h15, 16'h7C00, 16'h0440};
        vecs[2] = '{6'd3, 32'h0003_8040, 1, 7'h16, 16'h8000, 16'hBFFF, 7'h00, 16'h0000, 16'h0000};
        vecs[3] = '{6'd5, 32'h0001_0102, 2, 7'h08, 16'h5FFF, 16'h5042, 7'h09, 16'h0000, 16'h0080};
        vecs[4] = '{6'd4, 32'h0000_3F40, 2, 7'h14, 16'h3ABC, 16'h3FFF, 7'h15, 16'hFFFF, 16'h873F};
        vecs[5] = '{6'd5, 32'h0004_0908, 0, 7'h08, 16'h0000, 16'h0000, 7'h09, 16'h0000, 16'h0000};
        t4_addr = '{7'h08, 7'h09, 7'h14, 7'h15, 7'h16};
        t4_data = '{16'h00C3, 16'h0000, 16'h0145, 16'h0000, 16'h0082};

        mgmt_reset_n   = 1'b0;
        mgmt_address   = 6'd0;
        mgmt_write     = 1'b0;
        mgmt_writedata = 32'h0;
        mgmt_read      = 1'b0;
        repeat (3) @(negedge mgmt_clk);
        check("reset readdata", mgmt_readdata, 32'h0);
        check("reset waitrequest", mgmt_waitrequest, 1'b0);
        check("reset den", drp_den, 1'b0);
        check("reset dwe", drp_dwe, 1'b0);
        check("reset daddr", drp_daddr, 7'h0);
        check("reset di", drp_di, 16'h0);
        check("reset mmcm_rst", mmcm_rst, 1'b0);
        mgmt_reset_n = 1'b1;
        mm_read(6'd1, rdata);
        check("reset status", rdata, 32'h0);
        mm_read(6'd7, rdata);
        check("unmapped read", rdata, 32'h0);
        lock_auto = 1'b1;

        for (int v = 0; v < 6; v++) begin
            mem[vecs[v].ra] = vecs[v].ia;
            if (vecs[v].nreg == 2) mem[vecs[v].rb] = vecs[v].ib;
            base = log_n;
            w0   = wreq_cnt;
            r0   = rst_cnt;
            n    = den_norst;
            mm_write(vecs[v].addr, vecs[v].word);
            mm_write(6'd2, 32'h1);
            repeat (3) @(negedge mgmt_clk);
            wait_idle($sformatf("v%0d idle", v), 300);
            check($sformatf("v%0d drp count", v), log_n - base, 2 * vecs[v].nreg);
            check($sformatf("v%0d mmcm_rst after", v), mmcm_rst, 1'b0);
            if (vecs[v].nreg == 0) begin
                check($sformatf("v%0d no waitrequest", v), wreq_cnt - w0, 0);
                check($sformatf("v%0d no mmcm_rst", v), rst_cnt - r0, 0);
            end else begin
                check($sformatf("v%0d den under rst", v), den_norst - n, 0);
                check($sformatf("v%0d rd addr a", v), {log_w[base], log_a[base]}, {1'b0, vecs[v].ra});
                check($sformatf("v%0d wr addr a", v), {log_w[base+1], log_a[base+1]}, {1'b1, vecs[v].ra});
                check($sformatf("v%0d wr data a", v), log_d[base+1], vecs[v].ea);
            end
            if (vecs[v].nreg == 2) begin
                check($sformatf("v%0d rd addr b", v), {log_w[base+2], log_a[base+2]}, {1'b0, vecs[v].rb});
                check($sformatf("v%0d wr addr b", v), {log_w[base+3], log_a[base+3]}, {1'b1, vecs[v].rb});
                check($sformatf("v%0d wr data b", v), log_d[base+3], vecs[v].eb);
            end
        end

        // All three groups dirty; completion gated on lock.
        for (int a = 0; a < 5; a++) mem[t4_addr[a]] = 16'h0000;
        lock_auto = 1'b0;
        mm_write(6'd3, 32'h0000_0202);
        mm_write(6'd4, 32'h0000_0505);
        mm_write(6'd5, 32'h0000_0303);
        base = log_n;
        mm_write(6'd2, 32'h1);
        n = 0;
        while (log_n < base + 10 && n < 300) begin
            @(negedge mgmt_clk);
            n++;
        end
        repeat (10) @(negedge mgmt_clk);
        check("t4 drp count", log_n - base, 10);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t4 rd%0d addr", k), {log_w[base+2*k], log_a[base+2*k]}, {1'b0, t4_addr[k]});
            check($sformatf("t4 wr%0d addr", k), {log_w[base+2*k+1], log_a[base+2*k+1]}, {1'b1, t4_addr[k]});
            check($sformatf("t4 wr%0d data", k), log_d[base+2*k+1], t4_data[k]);
        end
        check("t4 busy before lock", mgmt_waitrequest, 1'b1);
        mm_read(6'd1, rdata);
        check("t4 status unlocked", rdata, 32'h2);
        fork
            begin
                mm_write(6'd3, 32'h0000_0404);
                t4_wr_done = 1'b1;
            end
        join_none
        repeat (5) @(negedge mgmt_clk);
        check("t4 stalled write pending", t4_wr_done, 1'b0);
        check("t4 no extra drp", log_n - base, 10);
        lock_force = 1'b1;
        wait_idle("t4 idle", 50);
        n = 0;
        while (!t4_wr_done && n < 50) begin
            @(negedge mgmt_clk);
            n++;
        end
        check("t4 stalled write done", t4_wr_done, 1'b1);
        mm_read(6'd1, rdata);
        check("t4 status locked", rdata, 32'h1);
        base = log_n;
        mm_write(6'd2, 32'h1);
        wait_idle("t4b idle", 300);
        check("t4b drp count", log_n - base, 2);
        check("t4b wr addr", log_a[base+1], 7'h16);
        check("t4b wr data", log_d[base+1], 16'h0104);
        lock_force = 1'b0;

        // Reset while the DRP write is outstanding.
        lock_auto = 1'b0;
        hold_wr   = 1'b1;
        base      = log_n;
        mm_write(6'd5, 32'h0000_0908);
        mm_write(6'd2, 32'h1);
        n = 0;
        while (log_n < base + 2 && n < 100) begin
            @(negedge mgmt_clk);
            n++;
        end
        repeat (3) @(negedge mgmt_clk);
        check("t5 rst held in wr_wait", mmcm_rst, 1'b1);
        mgmt_reset_n = 1'b0;
        #1;
        check("t5 den", drp_den, 1'b0);
        check("t5 dwe", drp_dwe, 1'b0);
        check("t5 mmcm_rst", mmcm_rst, 1'b0);
        check("t5 waitrequest", mgmt_waitrequest, 1'b0);
        @(negedge mgmt_clk);
        mgmt_reset_n = 1'b1;
        hold_wr      = 1'b0;
        mm_read(6'd1, rdata);
        check("t5 status", rdata, 32'h0);
        base = log_n;
        w0   = wreq_cnt;
        mm_write(6'd2, 32'h1);
        repeat (5) @(negedge mgmt_clk);
        check("t5 dirty cleared", log_n - base, 0);
        check("t5 no waitrequest", wreq_cnt - w0, 0);
        lock_auto = 1'b1;

`ifdef MMCM_DRP_TIMEOUT_EN
        hold_rd = 1'b1;
        mm_write(6'd5, 32'h0000_0908);
        mm_write(6'd2, 32'h1);
        n = 0;
        @(negedge mgmt_clk);
        while (mgmt_waitrequest && n < 100) begin
            @(negedge mgmt_clk);
            n++;
        end
        check("t6 waitrequest", mgmt_waitrequest, 1'b0);
        check("t6 mmcm_rst", mmcm_rst, 1'b0);
        check("t6 abort cycles in range", (n >= TMO) && (n <= TMO + 4), 1'b1);
        mm_read(6'd1, rdata);
        check("t6 error set", rdata[2], 1'b1);
        hold_rd = 1'b0;
        base = log_n;
        mm_write(6'd2, 32'h1);
        repeat (4) @(negedge mgmt_clk);
        check("t6 dirty cleared", log_n - base, 0);
        mm_read(6'd1, rdata);
        check("t6 error cleared", rdata[2], 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
